muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The module SHALL have parameter MUL_STAGES, default 2, giving the multiply latency in cycles from accept to `ok`; legal range is 1..4.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 The module SHALL have port resetn, input, 1 bit: reset, asynchronous assert, active-low.
REQ-004 The module SHALL have port valid, input, 1 bit: the execute stage holds a MULT/MULTU/DIV/DIVU instruction.
REQ-005 The module SHALL have port op, input, muldiv_op_t (2 bits): MULT=0, MULTU=1, DIV=2, DIVU=3.
REQ-006 The module SHALL have ports a and b, input, 32 bits each: rs and rt operands, already forwarded.
REQ-007 The module SHALL have port ack, input, 1 bit: the execute stage advances this cycle (!stallE).
REQ-008 The module SHALL have port flush, input, 1 bit: abort the operation (flushE or exception).
REQ-009 The module SHALL have port ok, output, 1 bit: hi and lo are valid; drives hazard mult_ok.
REQ-010 The module SHALL have ports hi and lo, output, 32 bits each: the result, consumed as hilo write data.
REQ-011 The module SHALL have port busy, output, 1 bit: the state is MUL or DIV.

Function
REQ-012 The FSM SHALL have states IDLE, MUL, DIV and DONE, encoded as muldiv_state_t.
REQ-013 IDLE & valid & !flush SHALL latch op, a and b and move to MUL (op<2) or DIV (op>=2); this cycle is the accept cycle.
REQ-014 MULT SHALL produce the signed 64-bit product and MULTU the unsigned one, with {hi,lo} = product.
REQ-015 MUL SHALL count MUL_STAGES-1 cycles and then enter DONE, so `ok` asserts exactly MUL_STAGES cycles after accept.
REQ-016 DIV SHALL run a restoring divide on magnitudes: 32 iterations plus one sign-fixup cycle, so `ok` asserts 33 cycles after accept.
REQ-017 The divide SHALL set lo = quotient truncated toward zero and hi = remainder carrying the dividend's sign.
REQ-018 For divide by zero (b==0), DIV SHALL skip iteration and reach DONE in 1 cycle with hi=a and lo=32'hFFFF_FFFF, for both DIV and DIVU.
REQ-019 DIV 32'h8000_0000 / 32'hFFFF_FFFF SHALL yield lo=32'h8000_0000 and hi=0, with no trap.
REQ-020 In DONE, `ok` SHALL be 1 and hi/lo stable; ack moves to IDLE; !ack holds DONE.
REQ-021 `ok` SHALL be 0 in every state other than DONE; hi and lo SHALL hold their last result until the next DONE.
REQ-022 A back-to-back muldiv instruction SHALL be accepted in IDLE on the cycle after ack, never in DONE.
REQ-023 Flush in any state SHALL move to IDLE on the next edge with ok=0 and discard the partial result.
REQ-024 Flush in the same cycle as valid in IDLE SHALL win, so nothing is accepted.
REQ-025 valid or operand changes while in MUL or DIV SHALL be ignored.

Reset
REQ-026 resetn=0 SHALL asynchronously force IDLE, ok=0, busy=0, hi=0, lo=0 and the iteration counter to 0, including mid-divide.
REQ-027 After resetn deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-028 With MULDIV_DIV_EARLY_EN defined, DIV/DIVU with |a| < |b| and b!=0 SHALL reach DONE 1 cycle after accept with lo=0 and hi=a.
REQ-029 With MULDIV_DIV_EARLY_EN undefined, every nonzero-divisor divide SHALL take exactly 33 cycles.

Structure
REQ-030 muldiv_pkg SHALL hold muldiv_op_t, muldiv_state_t, DIV_ITERS=32 and the divide-by-zero quotient constant.
REQ-031 The iterative divider SHALL be a sub-module div_core, with start/done handshake, signed flag, and abort driven by flush; the multiplier SHALL stay inline.

Verification
REQ-032 A bench SHALL drive MULT a=32'hFFFF_FFFE, b=3, check ok at cycle +2, and require hi=32'hFFFF_FFFF, lo=32'hFFFF_FFFA.
REQ-033 A bench SHALL drive DIV a=-7, b=2, check ok at cycle +33, and require lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-034 A bench SHALL drive DIVU a=100, b=0, check ok at cycle +1, and require hi=100, lo=32'hFFFF_FFFF.
REQ-035 A bench SHALL hold ack=0 for 5 cycles after ok, require ok and hi/lo to stay constant, then pulse ack and require ok=0 on the next cycle.
REQ-036 A bench SHALL assert flush at divide iteration 10, require IDLE and ok=0 next cycle, then run MULTU 7x6 and require lo=42, hi=0.
REQ-037 A bench SHALL drop resetn low at divide iteration 20 and require ok=0, hi=0, lo=0 and busy=0 immediately, without waiting for a clock.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int          DIV_ITERS = 32;
  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

  // Magnitude of x, treating it as two's complement only when sgn is set.
  function automatic logic [31:0] mag(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative restoring divider on magnitudes. The first iteration runs on the
// start edge; the cycle after the 32nd iteration presents sign-fixed results with done=1.
module div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        signed_op,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        run_q, run_d, negq_q, negq_d, negr_q, negr_d;
  logic [31:0] rem_in, quo_in, dvs_in;
  logic [32:0] shifted, trial;

  assign done      = run_q && (cnt_q == 6'(DIV_ITERS));
  assign quotient  = negq_q ? (~quo_q + 32'd1) : quo_q;
  assign remainder = negr_q ? (~rem_q + 32'd1) : rem_q;

  always_comb begin
    rem_in = rem_q;
    quo_in = quo_q;
    dvs_in = dvs_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    negq_d = negq_q;
    negr_d = negr_q;
    // A fresh start feeds the magnitudes straight into the first iteration.
    if (start && !run_q) begin
      rem_in = '0;
      quo_in = mag(dividend, signed_op);
      dvs_in = mag(divisor, signed_op);
      negq_d = signed_op && (dividend[31] ^ divisor[31]);
      negr_d = signed_op && dividend[31];
    end
    shifted = {rem_in, quo_in[31]};
    trial   = shifted - {1'b0, dvs_in};
    if (abort || done) begin
      run_d = 1'b0;
      cnt_d = '0;
    end else if (run_q || start) begin
      rem_d = trial[32] ? shifted[31:0] : trial[31:0];
      quo_d = {quo_in[30:0], ~trial[32]};
      dvs_d = dvs_in;
      cnt_d = cnt_q + 6'd1;
      run_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit: inline multiplier, iterative divider in div_core.
// Optional: define MULDIV_DIV_EARLY_EN to finish divides with |a| < |b| in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  muldiv_op_t  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ack,
  input  logic        flush,
  output logic        ok,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  muldiv_state_t state_q, state_d;
  logic [31:0]   a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic          msg_q, msg_d;
  logic [1:0]    mcnt_q, mcnt_d;
  logic [31:0]   ma, mb;
  logic          msg;
  logic [63:0]   product;
  logic          div_start, div_done;
  logic [31:0]   div_quo, div_rem;

  // Operands come straight from the ports on the accept cycle (single-stage case).
  assign ma      = (state_q == IDLE) ? a : a_q;
  assign mb      = (state_q == IDLE) ? b : b_q;
  assign msg     = (state_q == IDLE) ? !op[0] : msg_q;
  assign product = {{32{msg & ma[31]}}, ma} * {{32{msg & mb[31]}}, mb};

  assign ok   = (state_q == DONE);
  assign busy = (state_q == MUL) || (state_q == DIV);
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    msg_d     = msg_q;
    mcnt_d    = mcnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    div_start = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (valid) begin
          a_d    = a;
          b_d    = b;
          msg_d  = !op[0];
          mcnt_d = '0;
          if (!op[1]) begin
            if (MUL_STAGES == 1) begin
              state_d      = DONE;
              {hi_d, lo_d} = product;
            end else begin
              state_d = MUL;
            end
          end else if (b == 32'd0) begin
            state_d = DONE;
            hi_d    = a;
            lo_d    = DIV0_QUOT;
          end
`ifdef MULDIV_DIV_EARLY_EN
          else if (mag(a, !op[0]) < mag(b, !op[0])) begin
            state_d = DONE;
            hi_d    = a;
            lo_d    = '0;
          end
`endif
          else begin
            state_d   = DIV;
            div_start = 1'b1;
          end
        end
        MUL: if (mcnt_q == 2'(MUL_STAGES - 2)) begin
          state_d      = DONE;
          {hi_d, lo_d} = product;
        end else begin
          mcnt_d = mcnt_q + 2'd1;
        end
        DIV: if (div_done) begin
          state_d = DONE;
          hi_d    = div_rem;
          lo_d    = div_quo;
        end
        DONE: if (ack) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      msg_q   <= 1'b0;
      mcnt_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      msg_q   <= msg_d;
      mcnt_q  <= mcnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  div_core u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .signed_op (!op[0]),
    .abort     (flush),
    .dividend  (a),
    .divisor   (b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: model-driven vector table plus corner-case sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int MS = 2;

  logic        clk = 1'b0;
  logic        resetn, valid, ack, flush;
  muldiv_op_t  op;
  logic [31:0] a, b, hi, lo;
  logic        ok, busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } vec_t;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[12];

  muldiv_unit #(.MUL_STAGES(MS)) dut (
    .clk(clk), .resetn(resetn), .valid(valid), .op(op), .a(a), .b(b),
    .ack(ack), .flush(flush), .ok(ok), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model built on the simulator's own 64-bit arithmetic.
  function automatic vec_t mk(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    vec_t v;
    logic signed [63:0] sx, sy, q, r;
    logic [63:0] p;
    v.op = o; v.a = x; v.b = y;
    sx = o[0] ? {32'b0, x} : {{32{x[31]}}, x};
    sy = o[0] ? {32'b0, y} : {{32{y[31]}}, y};
    if (!o[1]) begin
      p = sx * sy;
      {v.hi, v.lo} = p;
      v.lat = MS;
    end else if (y == 32'd0) begin
      v.hi = x; v.lo = 32'hFFFF_FFFF; v.lat = 1;
    end else begin
      q = sx / sy;
      r = sx % sy;
      v.lo = q[31:0]; v.hi = r[31:0]; v.lat = 33;
`ifdef MULDIV_DIV_EARLY_EN
      if ((sx < 0 ? -sx : sx) < (sy < 0 ? -sy : sy)) v.lat = 1;
`endif
    end
    return v;
  endfunction

  // Issue one op, wait (bounded) for ok, compare, hold DONE for `hold` cycles, then ack.
  task automatic do_op(input string nm, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                       input int lat, input int hold);
    exp_t e;
    int n;
    valid = 1'b1; op = muldiv_op_t'(o); a = x; b = y;
    sb_q.push_back('{hi: eh, lo: el, lat: lat});
    @(posedge clk); #1;
    valid = 1'b0;
    n = 1;
    while (!ok && n < 100) begin
      valid = 1'($urandom);
      a = $urandom; b = $urandom;
      @(posedge clk); #1;
      n++;
    end
    valid = 1'b0;
    e = sb_q.pop_front();
    chk({nm, " latency"}, 64'(n), 64'(e.lat));
    chk({nm, " hilo"}, {hi, lo}, {e.hi, e.lo});
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      chk({nm, " hold ok"}, 64'(ok), 64'(1));
      chk({nm, " hold hilo"}, {hi, lo}, {e.hi, e.lo});
    end
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    chk({nm, " ok after ack"}, 64'(ok), 64'(0));
    chk({nm, " busy after ack"}, 64'(busy), 64'(0));
  endtask

  initial begin
    resetn = 1'b0; valid = 1'b0; ack = 1'b0; flush = 1'b0;
    op = OP_MULT; a = '0; b = '0;

    vecs[0]  = mk(2'd0, 32'hFFFF_FFFE, 32'd3);
    vecs[1]  = mk(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    vecs[2]  = mk(2'd0, 32'h8000_0000, 32'h8000_0000);
    vecs[3]  = mk(2'd2, 32'hFFFF_FFF9, 32'd2);
    vecs[4]  = mk(2'd3, 32'd100, 32'd0);
    vecs[5]  = mk(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    vecs[6]  = mk(2'd3, 32'hFFFF_FFFF, 32'd7);
    vecs[7]  = mk(2'd2, 32'd7, 32'hFFFF_FFFE);
    vecs[8]  = mk(2'd2, 32'hFFFF_FFFB, 32'd0);
    vecs[9]  = mk(2'd3, 32'd3, 32'd10);
    vecs[10] = mk(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    vecs[11] = mk(2'd2, 32'h7FFF_FFFF, 32'd1);

    #12;
    chk("reset ok", 64'(ok), 64'(0));
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            vecs[i].hi, vecs[i].lo, vecs[i].lat, 0);

    // Literal expectations for the headline cases.
    do_op("mult_neg", 2'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 2, 0);
    do_op("div_neg7", 2'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 0);
    do_op("divu_zero", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 0);
    do_op("div_ovf", 2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33, 0);
    do_op("hold5", 2'd1, 32'd9, 32'd9, 32'd0, 32'd81, 2, 5);

    // Flush together with valid in IDLE: nothing accepted.
    valid = 1'b1; flush = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd5;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush_vs_valid busy", 64'(busy), 64'(0));
    chk("flush_vs_valid ok", 64'(ok), 64'(0));

    // Flush at divide iteration 10.
    valid = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 1; k < 10; k++) begin @(posedge clk); #1; end
    chk("mid_div busy", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush ok", 64'(ok), 64'(0));
    chk("flush busy", 64'(busy), 64'(0));
    chk("flush keeps hilo", {hi, lo}, {32'd0, 32'd81});
    do_op("multu_7x6", 2'd1, 32'd7, 32'd6, 32'd0, 32'd42, 2, 0);

    // Asynchronous reset at divide iteration 20.
    valid = 1'b1; op = OP_DIVU; a = 32'd12345; b = 32'd17;
    @(posedge clk); #1;
    valid = 1'b0;
    for (int k = 1; k < 20; k++) begin @(posedge clk); #1; end
    chk("pre_reset busy", 64'(busy), 64'(1));
    #1 resetn = 1'b0;
    #1;
    chk("async rst ok", 64'(ok), 64'(0));
    chk("async rst busy", 64'(busy), 64'(0));
    chk("async rst hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_op("post_reset", 2'd3, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1, 0);
    do_op("post_reset_div", 2'd3, 32'd12345, 32'd17, 32'd3, 32'd726, 33, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
